ws2812_frame_scheduler: RTL and testbench
=========================================

Name: ws2812_frame_scheduler

Overview:
- Upstream stage of ws2812_driver. Holds a staging pixel buffer written by the pattern logic and a display buffer presented to the driver.
- Launches one driver frame per refresh period, using the driver's start/busy handshake.
- Commits staging to display only at a frame launch, so the driver never sees a half-updated frame.
- Counts completed frames and flags a driver that never responds.

Parameters:
- LED_COUNT, 8, number of pixels; drv_data width is LED_COUNT*24.
- ADDR_W, 3, pixel address width; must satisfy 2^ADDR_W >= LED_COUNT.
- REFRESH_CYCLES, 50000, clk cycles per refresh tick (1 ms at 50 MHz); minimum 2.
- BUSY_TIMEOUT, 64, cycles to wait for drv_busy to rise after start deasserts.

Ports:
- clk  in  1  system clock, 50 MHz.
- reset  in  1  synchronous, active-low; asserted when 0, sampled on the rising edge of clk.
- wr_en  in  1  write one pixel into the staging buffer.
- wr_addr  in  ADDR_W  pixel index; pixel i occupies bits [i*24 +: 24].
- wr_data  in  24  pixel colour word, passed through unchanged.
- commit  in  1  single-cycle request to publish staging at the next launch.
- commit_pending  out  1  a commit is waiting for a launch.
- drv_data  out  LED_COUNT*24  display buffer, wired to the driver's data port.
- drv_start  out  1  start pulse to the driver.
- drv_busy  in  1  busy from the driver.
- frame_count  out  16  completed frames, wraps modulo 2^16.
- timeout_err  out  1  sticky; set when the driver fails to raise busy.

Behaviour:
- Reset (reset==0 at a clk edge): staging=0, drv_data=0, drv_start=0, commit_pending=0, frame_count=0, timeout_err=0, refresh counter=0, tick_pending=0, FSM=IDLE. Outputs take these values in the cycle after the edge. This applies at any point, including mid-frame.
- Refresh counter: free-running 0..REFRESH_CYCLES-1. At the wrap edge it sets tick_pending. Ticks that arrive while tick_pending is already 1 are merged; there is no queue beyond depth 1.
- Writes: staging[wr_addr] is updated at the edge when wr_en=1. If wr_addr>=LED_COUNT the write is ignored and no state changes. Writes are accepted in every FSM state.
- Commit: commit=1 sets commit_pending. It remains set until a launch consumes it. Repeated commits are idempotent.
- FSM states:
  - IDLE: if tick_pending=1 and drv_busy=0, go to START. This transition edge is the launch edge. Otherwise stay in IDLE.
  - Launch edge actions: clear tick_pending. If commit_pending=1, copy drv_data<=staging and clear commit_pending. Set drv_start=1.
  - START: hold drv_start=1 for exactly 2 cycles (the driver needs more than one cycle of start). Then set drv_start=0 and go to WAIT_HI.
  - WAIT_HI: if drv_busy=1, go to WAIT_LO. If BUSY_TIMEOUT cycles pass with drv_busy=0, set timeout_err=1 and go to IDLE; frame_count is not incremented.
  - WAIT_LO: on drv_busy=0, increment frame_count and go to IDLE.
- drv_data changes only on a launch edge or on reset. It is stable throughout START, WAIT_HI and WAIT_LO.
- Simultaneous write and launch: the copy takes the pre-edge staging value. The write lands in staging only and appears at the next committed launch.
- Simultaneous commit and launch: the launch uses the pre-edge commit_pending value. A commit arriving on the launch edge leaves commit_pending=1 for the following launch.
- Tick arriving while not IDLE: tick_pending stays set, and launch happens on the first IDLE cycle with drv_busy=0.
- drv_busy=1 while IDLE: launch is held off. tick_pending is retained.
- timeout_err is cleared only by reset.
- Latency: counter wrap edge at cycle T sets tick_pending, visible at T+1. If the FSM is IDLE with drv_busy=0, drv_start is high in cycles T+2 and T+3.

Test Plan:
- LED_COUNT=8, REFRESH_CYCLES=1000, real ws2812_driver attached, write pixel i = 24'hFF0000>>i, commit → first launch has drv_data[i*24+:24]=24'hFF0000>>i, drv_start high for exactly 2 cycles, frame_count=1 after busy falls, commit_pending=0.
- Write pixel 3=24'h00FF00 without commit across 3 refresh periods → drv_data unchanged, frame_count advances by 3.
- Issue commit and a write to pixel 0=24'h0000FF on the exact launch edge → the current frame uses the old pixel 0, commit_pending=1 afterwards, the next frame shows 24'h0000FF.
- Behavioural driver model that never raises busy, BUSY_TIMEOUT=64 → timeout_err=1 exactly 64 cycles after drv_start falls, FSM back in IDLE, frame_count=0, the next tick relaunches.
- Driver model with busy held for 1500 cycles (longer than the refresh period) → only one pending tick is kept, relaunch occurs 1 cycle after busy falls, no extra start pulses.
- Reset low for one edge during WAIT_LO with frame_count=5 → next cycle drv_start=0, drv_data=0, frame_count=0, timeout_err=0; also write wr_addr=7 vs LED_COUNT=7 → write ignored.

Source files
------------

// File: rtl/ws2812_frame_scheduler.sv
// Double-buffered pixel store feeding ws2812_driver: pattern logic fills staging,
// and each refresh tick launches one frame through the driver's start/busy handshake.
module ws2812_frame_scheduler #(
  parameter int LED_COUNT      = 8,
  parameter int ADDR_W         = 3,
  parameter int REFRESH_CYCLES = 50000,
  parameter int BUSY_TIMEOUT   = 64
) (
  input  logic                    clk_i,
  input  logic                    reset_ni,
  input  logic                    wr_en_i,
  input  logic [ADDR_W-1:0]       wr_addr_i,
  input  logic [23:0]             wr_data_i,
  input  logic                    commit_i,
  output logic                    commit_pending_o,
  output logic [LED_COUNT*24-1:0] drv_data_o,
  output logic                    drv_start_o,
  input  logic                    drv_busy_i,
  output logic [15:0]             frame_count_o,
  output logic                    timeout_err_o
);

  localparam int DW    = LED_COUNT * 24;
  localparam int CNT_W = $clog2(REFRESH_CYCLES);
  localparam int TO_W  = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] REFRESH_LAST = CNT_W'(REFRESH_CYCLES - 1);
  localparam logic [TO_W-1:0]  TIMEOUT_LAST = TO_W'(BUSY_TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_HI, WAIT_LO} state_t;

  state_t            state_q, state_d;
  logic [DW-1:0]     staging_q, staging_d;
  logic [DW-1:0]     display_q, display_d;
  logic [CNT_W-1:0]  refresh_q, refresh_d;
  logic [TO_W-1:0]   wait_q, wait_d;
  logic [15:0]       frames_q, frames_d;
  logic              tick_q, tick_d;
  logic              pending_q, pending_d;
  logic              start_q, start_d;
  logic              start_hold_q, start_hold_d;
  logic              timeout_q, timeout_d;
  logic              wrap_s;
  logic              launch_s;

  // Next-state logic for buffers, refresh timing and the launch handshake FSM
  always_comb begin
    state_d      = state_q;
    start_d      = start_q;
    start_hold_d = start_hold_q;
    wait_d       = wait_q;
    frames_d     = frames_q;
    timeout_d    = timeout_q;
    staging_d    = staging_q;

    wrap_s   = (refresh_q == REFRESH_LAST);
    launch_s = (state_q == IDLE) && tick_q && !drv_busy_i;

    refresh_d = wrap_s ? {CNT_W{1'b0}} : refresh_q + CNT_W'(1);
    // A wrap coinciding with a launch is a fresh tick, so set wins over clear
    tick_d    = wrap_s | (tick_q & ~launch_s);
    pending_d = commit_i | (pending_q & ~launch_s);
    display_d = (launch_s && pending_q) ? staging_q : display_q;

    for (int i = 0; i < LED_COUNT; i++) begin
      if (wr_en_i && (wr_addr_i == ADDR_W'(i))) begin
        staging_d[i*24 +: 24] = wr_data_i;
      end else begin
        staging_d[i*24 +: 24] = staging_q[i*24 +: 24];
      end
    end

    case (state_q)
      IDLE: begin
        if (launch_s) begin
          state_d      = START;
          start_d      = 1'b1;
          start_hold_d = 1'b0;
        end else begin
          state_d = IDLE;
        end
      end
      START: begin
        if (start_hold_q) begin
          state_d = WAIT_HI;
          start_d = 1'b0;
          wait_d  = {TO_W{1'b0}};
        end else begin
          start_hold_d = 1'b1;
        end
      end
      WAIT_HI: begin
        if (drv_busy_i) begin
          state_d = WAIT_LO;
        end else if (wait_q == TIMEOUT_LAST) begin
          state_d   = IDLE;
          timeout_d = 1'b1;
        end else begin
          wait_d = wait_q + TO_W'(1);
        end
      end
      WAIT_LO: begin
        if (!drv_busy_i) begin
          state_d  = IDLE;
          frames_d = frames_q + 16'd1;
        end else begin
          state_d = WAIT_LO;
        end
      end
      default: begin
        state_d = IDLE;
        start_d = 1'b0;
      end
    endcase
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q      <= IDLE;
      staging_q    <= {DW{1'b0}};
      display_q    <= {DW{1'b0}};
      refresh_q    <= {CNT_W{1'b0}};
      wait_q       <= {TO_W{1'b0}};
      frames_q     <= 16'd0;
      tick_q       <= 1'b0;
      pending_q    <= 1'b0;
      start_q      <= 1'b0;
      start_hold_q <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      staging_q    <= staging_d;
      display_q    <= display_d;
      refresh_q    <= refresh_d;
      wait_q       <= wait_d;
      frames_q     <= frames_d;
      tick_q       <= tick_d;
      pending_q    <= pending_d;
      start_q      <= start_d;
      start_hold_q <= start_hold_d;
      timeout_q    <= timeout_d;
    end
  end

  assign commit_pending_o = pending_q;
  assign drv_data_o       = display_q;
  assign drv_start_o      = start_q;
  assign frame_count_o    = frames_q;
  assign timeout_err_o    = timeout_q;

endmodule

// File: tb/tb_ws2812_frame_scheduler.sv
// Bench for ws2812_frame_scheduler: random pixels and driver timing, scored against
// a reference of staging/display arrays and launch times derived from tick arithmetic.
`timescale 1ns/1ps
module tb_ws2812_frame_scheduler;
  localparam int LED_COUNT = 7;
  localparam int ADDR_W    = 3;
  localparam int R         = 100;
  localparam int TMO       = 64;
  localparam int DW        = LED_COUNT * 24;

  logic              clk = 1'b0;
  logic              reset_ni;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [23:0]       wr_data;
  logic              commit;
  logic              commit_pending;
  logic [DW-1:0]     drv_data;
  logic              drv_start;
  logic              drv_busy;
  logic [15:0]       frame_count;
  logic              timeout_err;

  always #5 clk = ~clk;

  ws2812_frame_scheduler #(
    .LED_COUNT(LED_COUNT), .ADDR_W(ADDR_W), .REFRESH_CYCLES(R), .BUSY_TIMEOUT(TMO)
  ) dut (
    .clk_i(clk), .reset_ni(reset_ni), .wr_en_i(wr_en), .wr_addr_i(wr_addr),
    .wr_data_i(wr_data), .commit_i(commit), .commit_pending_o(commit_pending),
    .drv_data_o(drv_data), .drv_start_o(drv_start), .drv_busy_i(drv_busy),
    .frame_count_o(frame_count), .timeout_err_o(timeout_err)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;   // cycle 0 is the first cycle after the last reset edge

  always @(posedge clk) cyc <= reset_ni ? cyc + 1 : 0;

  // Driver stand-in: busy rises as start falls and lasts busy_len cycles
  int busy_len   = 20;
  bit never_busy = 1'b0;
  bit hold_busy  = 1'b0;
  initial begin : driver_model
    int busy_left;
    bit start_prev;
    busy_left  = 0;
    start_prev = 1'b0;
    drv_busy   = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (start_prev && !drv_start && !never_busy) busy_left = busy_len;
      else if (busy_left > 0) busy_left--;
      start_prev = drv_start;
      drv_busy   = hold_busy || (busy_left > 0);
    end
  end

  logic [23:0] stage_m [LED_COUNT];
  logic [23:0] disp_m  [LED_COUNT];
  bit pend_m;
  int frames_m;
  int last_launch_c;  // cycle ending in the most recent launch edge
  int idle_c;         // first cycle the FSM can launch again (IDLE, busy low)

  function automatic logic [DW-1:0] disp_vec();
    logic [DW-1:0] v;
    for (int i = 0; i < LED_COUNT; i++) v[i*24 +: 24] = disp_m[i];
    return v;
  endfunction

  // Ticks are visible in cycles that are multiples of R; one unconsumed tick suffices
  function automatic int predict_start(int last_c, int ready_c);
    int tick_c;
    tick_c = (last_c / R + 1) * R;
    return ((ready_c > tick_c) ? ready_c : tick_c) + 1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < LED_COUNT; i++) begin
      stage_m[i] = 24'h0;
      disp_m[i]  = 24'h0;
    end
    pend_m = 1'b0; frames_m = 0; last_launch_c = 0; idle_c = 0;
  endtask

  task automatic model_launch();
    if (pend_m) begin
      for (int i = 0; i < LED_COUNT; i++) disp_m[i] = stage_m[i];
      pend_m = 1'b0;
    end
  endtask

  task automatic write_pixel(input int addr, input logic [23:0] data);
    wr_en = 1'b1; wr_addr = addr[ADDR_W-1:0]; wr_data = data;
    @(negedge clk);
    wr_en = 1'b0;
    if (addr < LED_COUNT) stage_m[addr] = data;
  endtask

  task automatic do_commit();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
    pend_m = 1'b1;
  endtask

  task automatic measure_start(output int s, output int width, output bit ok);
    int n;
    n = 0; ok = 1'b0; s = -1; width = 0;
    while (drv_start !== 1'b1 && n < 800) begin @(negedge clk); n++; end
    if (drv_start === 1'b1) begin
      ok = 1'b1; s = cyc;
      while (drv_start === 1'b1 && width < 8) begin width++; @(negedge clk); end
    end
  endtask

  task automatic wait_frame_done(output int b, output bit ok);
    int n;
    n = 0; ok = 1'b0; b = -1;
    while (drv_busy !== 1'b1 && n < 600) begin @(negedge clk); n++; end
    if (drv_busy === 1'b1) begin
      while (drv_busy === 1'b1 && n < 600) begin @(negedge clk); n++; end
      if (drv_busy === 1'b0) begin ok = 1'b1; b = cyc; @(negedge clk); end
    end
  endtask

  task automatic test_reset();
    reset_ni = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = 24'h0; commit = 1'b0;
    repeat (3) @(negedge clk);
    model_reset();
    checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL reset_start: got %b want 0", drv_start); end
    checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL reset_data: got %h want %h", drv_data, disp_vec()); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL reset_pending: got %b want 0", commit_pending); end
    checks++; if (frame_count !== 16'(frames_m)) begin errors++; $display("FAIL reset_frames: got %0d want %0d", frame_count, frames_m); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", timeout_err); end
    reset_ni = 1'b1;
  endtask

  task automatic test_first_frame();
    int s, w, b, pred; bit ok;
    for (int i = 0; i < LED_COUNT; i++) write_pixel(i, 24'hFF0000 >> i);
    do_commit();
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL first_pending_set: got %b want 1", commit_pending); end
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || s !== pred) begin errors++; $display("FAIL first_start: got cycle %0d want %0d", s, pred); end
    checks++; if (w !== 2) begin errors++; $display("FAIL first_width: got %0d want 2", w); end
    checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL first_data: got %h want %h", drv_data, disp_vec()); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL first_pending_clr: got %b want 0", commit_pending); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
    checks++; if (!ok || frame_count !== 16'(frames_m)) begin errors++; $display("FAIL first_frames: got %0d want %0d", frame_count, frames_m); end
  endtask

  task automatic test_no_commit();
    int s, w, b, pred; bit ok;
    write_pixel(3, 24'h00FF00);
    write_pixel($urandom_range(0, LED_COUNT - 1), 24'($urandom));
    for (int k = 0; k < 3; k++) begin
      busy_len = $urandom_range(5, 40);
      pred = predict_start(last_launch_c, idle_c);
      measure_start(s, w, ok);
      model_launch(); last_launch_c = s - 1;
      checks++; if (!ok || s !== pred) begin errors++; $display("FAIL nocommit_start%0d: got cycle %0d want %0d", k, s, pred); end
      checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL nocommit_data%0d: got %h want %h", k, drv_data, disp_vec()); end
      wait_frame_done(b, ok);
      frames_m++; idle_c = b + 1;
      checks++; if (!ok || frame_count !== 16'(frames_m)) begin errors++; $display("FAIL nocommit_frames%0d: got %0d want %0d", k, frame_count, frames_m); end
    end
  endtask

  task automatic test_commit_on_launch();
    int s, w, b, pred, n; bit ok;
    logic [23:0] a, bd;
    a = 24'($urandom);
    write_pixel(0, a);
    do_commit();
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || drv_data !== disp_vec()) begin errors++; $display("FAIL col_setup_data: got %h want %h", drv_data, disp_vec()); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
    // The launch edge ends the first cycle in which the next tick is visible
    n = 0;
    while (cyc % R != 0 && n < 2 * R) begin @(negedge clk); n++; end
    bd = 24'h0000FF ^ (24'($urandom) & 24'hFF0000);
    wr_en = 1'b1; wr_addr = '0; wr_data = bd; commit = 1'b1;
    @(negedge clk);
    wr_en = 1'b0; commit = 1'b0;
    model_launch(); stage_m[0] = bd; pend_m = 1'b1; last_launch_c = cyc - 1;
    checks++; if (drv_start !== 1'b1) begin errors++; $display("FAIL col_start: got %b want 1", drv_start); end
    checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL col_old_data: got %h want %h", drv_data, disp_vec()); end
    checks++; if (commit_pending !== 1'b1) begin errors++; $display("FAIL col_pending: got %b want 1", commit_pending); end
    @(negedge clk);
    checks++; if (drv_start !== 1'b1) begin errors++; $display("FAIL col_start_hold: got %b want 1", drv_start); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
    checks++; if (!ok || frame_count !== 16'(frames_m)) begin errors++; $display("FAIL col_frames: got %0d want %0d", frame_count, frames_m); end
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || s !== pred) begin errors++; $display("FAIL col_next_start: got cycle %0d want %0d", s, pred); end
    checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL col_new_data: got %h want %h", drv_data, disp_vec()); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL col_pending_clr: got %b want 0", commit_pending); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
  endtask

  task automatic test_timeout();
    int s, w, b, pred, n; bit ok;
    never_busy = 1'b1;
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || s !== pred) begin errors++; $display("FAIL tmo_start: got cycle %0d want %0d", s, pred); end
    // start falls in cycle s+2; the error must appear exactly TMO cycles later
    n = 0;
    while (cyc < s + 1 + TMO && n < 200) begin @(negedge clk); n++; end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL tmo_early: got %b want 0", timeout_err); end
    @(negedge clk);
    checks++; if (timeout_err !== 1'b1) begin errors++; $display("FAIL tmo_set: got %b want 1", timeout_err); end
    checks++; if (frame_count !== 16'(frames_m)) begin errors++; $display("FAIL tmo_frames: got %0d want %0d", frame_count, frames_m); end
    never_busy = 1'b0; idle_c = s + 2 + TMO;
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || s !== pred) begin errors++; $display("FAIL tmo_relaunch: got cycle %0d want %0d", s, pred); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
    checks++; if (!ok || frame_count !== 16'(frames_m) || timeout_err !== 1'b1) begin
      errors++; $display("FAIL tmo_after: got frames %0d err %b want %0d 1", frame_count, timeout_err, frames_m);
    end
  endtask

  task automatic test_long_busy();
    int s, w, b, pred; bit ok;
    busy_len = 2 * R + 50;
    for (int k = 0; k < 3; k++) begin
      pred = predict_start(last_launch_c, idle_c);
      measure_start(s, w, ok);
      model_launch(); last_launch_c = s - 1;
      checks++; if (!ok || s !== pred || w !== 2) begin
        errors++; $display("FAIL long_start%0d: got cycle %0d width %0d want %0d 2", k, s, w, pred);
      end
      busy_len = $urandom_range(10, 30);
      wait_frame_done(b, ok);
      frames_m++; idle_c = b + 1;
      checks++; if (!ok || frame_count !== 16'(frames_m)) begin errors++; $display("FAIL long_frames%0d: got %0d want %0d", k, frame_count, frames_m); end
    end
  endtask

  task automatic test_idle_hold();
    int s, w, b, pred, n, y; bit ok;
    n = 0;
    while (cyc % R != 90 && n < 2 * R) begin @(negedge clk); n++; end
    hold_busy = 1'b1;
    while (cyc % R != 30 && n < 4 * R) begin @(negedge clk); n++; end
    hold_busy = 1'b0; y = cyc; idle_c = y + 1;
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || s !== pred) begin errors++; $display("FAIL hold_start: got cycle %0d want %0d", s, pred); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
    checks++; if (!ok || frame_count !== 16'(frames_m)) begin errors++; $display("FAIL hold_frames: got %0d want %0d", frame_count, frames_m); end
  endtask

  task automatic test_reset_midframe();
    int s, w, b, pred; bit ok;
    write_pixel(4, 24'($urandom) | 24'h000001);
    do_commit();
    busy_len = 40;
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || drv_data !== disp_vec()) begin errors++; $display("FAIL rst_setup_data: got %h want %h", drv_data, disp_vec()); end
    repeat (10) @(negedge clk);
    do_commit();
    reset_ni = 1'b0;
    @(negedge clk);
    model_reset();
    checks++; if (drv_start !== 1'b0) begin errors++; $display("FAIL rst_mid_start: got %b want 0", drv_start); end
    checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL rst_mid_data: got %h want %h", drv_data, disp_vec()); end
    checks++; if (frame_count !== 16'(frames_m)) begin errors++; $display("FAIL rst_mid_frames: got %0d want %0d", frame_count, frames_m); end
    checks++; if (timeout_err !== 1'b0) begin errors++; $display("FAIL rst_mid_timeout: got %b want 0", timeout_err); end
    checks++; if (commit_pending !== 1'b0) begin errors++; $display("FAIL rst_mid_pending: got %b want 0", commit_pending); end
    reset_ni = 1'b1;
    write_pixel(7, 24'($urandom) | 24'h800000);
    write_pixel(2, 24'($urandom));
    do_commit();
    pred = predict_start(last_launch_c, idle_c);
    measure_start(s, w, ok);
    model_launch(); last_launch_c = s - 1;
    checks++; if (!ok || s !== pred) begin errors++; $display("FAIL rst_relaunch: got cycle %0d want %0d", s, pred); end
    checks++; if (drv_data !== disp_vec()) begin errors++; $display("FAIL oob_write_data: got %h want %h", drv_data, disp_vec()); end
    wait_frame_done(b, ok);
    frames_m++; idle_c = b + 1;
    checks++; if (!ok || frame_count !== 16'(frames_m)) begin errors++; $display("FAIL rst_frames: got %0d want %0d", frame_count, frames_m); end
  endtask

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_first_frame();
    test_no_commit();
    test_commit_on_launch();
    test_timeout();
    test_long_busy();
    test_idle_hold();
    test_reset_midframe();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
